ring_phase_sequencer: RTL and testbench

Sequencer that steps a one-hot phase ring and drives a 7-segment pattern per phase. Each phase has a programmable dwell time measured in prescaled ticks, with run/stop, single-step and optional reverse direction. Sits between the tile's user inputs and `uo_out`, replacing a free-running shift ring with a controlled scheduler for the same display datapath.

---
 rtl/ring_seq_pkg.sv | 30 +++
 rtl/ring_phase_sequencer_tick_prescaler.sv | 59 +++++
 rtl/ring_phase_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_ring_phase_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ring_seq_pkg.sv
// ---------------------------------------------------------------------------
// ring_seq_pkg
// Shared definitions for the ring phase sequencer:
//   state_e      - sequencer states (STOP / RUN / STEP)
//   PHASE_IDX_W  - width of the binary phase index
//   SEG_LUT      - 7-segment {g,f,e,d,c,b,a} pattern per phase index
//                  ("H", "E", "L", "P", then blank)
//   seg_of()     - helper returning the pattern for a phase index
// ---------------------------------------------------------------------------
package ring_seq_pkg;

    localparam int PHASE_IDX_W = 3;

    typedef enum logic [1:0] {
        STOP = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } state_e;

    // Element 0 is the rightmost entry of the concatenation.
    localparam logic [7:0][6:0] SEG_LUT = {
        7'h00, 7'h00, 7'h00, 7'h00,
        7'h73, 7'h38, 7'h79, 7'h76
    };

    function automatic logic [6:0] seg_of(input logic [PHASE_IDX_W-1:0] idx);
        return SEG_LUT[idx];
    endfunction

endpackage

// File: rtl/ring_phase_sequencer_tick_prescaler.sv
// ---------------------------------------------------------------------------
// tick_prescaler
// Divides the clock into one-cycle ticks, one every TICK_DIV enabled cycles.
// The count runs 0..TICK_DIV-1; the tick is registered, so it is high in the
// cycle after the count reaches TICK_DIV-1. This gives a fresh start (clr,
// then en) exactly TICK_DIV+1 cycles to the first tick cycle boundary seen by
// the sequencer's registered outputs.
//
// Ports:
//   clk  in  clock, rising edge
//   rst  in  asynchronous active-high reset
//   clr  in  synchronous clear of count and pending tick (priority over en)
//   en   in  count enable
//   tick out one-cycle tick pulse
// ---------------------------------------------------------------------------
module tick_prescaler #(
    parameter int TICK_DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == LAST) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/ring_phase_sequencer.sv
// ---------------------------------------------------------------------------
// ring_phase_sequencer
// Steps a one-hot phase ring and drives a 7-segment pattern per phase. Each
// phase lasts (dwell+1) prescaled ticks in RUN; STEP advances exactly once
// from STOP. All outputs are registered and change on the same edge.
//
// Optional feature macro: RING_REVERSE_EN
//   defined   - dir=1 walks the ring backwards (0 wraps to NUM_PHASES-1)
//   undefined - dir is ignored and only forward stepping is built
//
// Ports:
//   clk           in   clock, rising edge
//   rst           in   asynchronous active-high reset
//   run           in   level, 1 = auto-advance
//   step          in   single-cycle pulse, advance once while stopped
//   dir           in   0 = forward, 1 = reverse (see macro above)
//   cfg_we        in   dwell register write strobe
//   cfg_addr      in   phase index to write (>= NUM_PHASES is dropped)
//   cfg_dwell     in   dwell value
//   phase_onehot  out  current phase, one-hot
//   phase_idx     out  current phase, binary
//   seg           out  {g,f,e,d,c,b,a} pattern for current phase
//   phase_strobe  out  one-cycle pulse on the edge the phase changes
//   running       out  1 while in RUN
// ---------------------------------------------------------------------------
module ring_phase_sequencer
    import ring_seq_pkg::*;
#(
    parameter int NUM_PHASES = 5,
    parameter int DWELL_W    = 8,
    parameter int TICK_DIV   = 1000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run,
    input  logic                   step,
    input  logic                   dir,
    input  logic                   cfg_we,
    input  logic [2:0]             cfg_addr,
    input  logic [DWELL_W-1:0]     cfg_dwell,
    output logic [NUM_PHASES-1:0]  phase_onehot,
    output logic [2:0]             phase_idx,
    output logic [6:0]             seg,
    output logic                   phase_strobe,
    output logic                   running
);

    localparam logic [PHASE_IDX_W-1:0] LAST_IDX = PHASE_IDX_W'(NUM_PHASES - 1);

    state_e                  state_q, state_d;
    logic [PHASE_IDX_W-1:0]  idx_q, idx_d, adv_idx;
    logic [NUM_PHASES-1:0]   onehot_q, onehot_d;
    logic [6:0]              seg_q, seg_d;
    logic                    strobe_q, strobe_d;
    logic                    running_q, running_d;
    logic [DWELL_W-1:0]      dwell_cnt_q, dwell_cnt_d;
    logic [DWELL_W-1:0]      cur_dwell;
    logic [DWELL_W-1:0]      dwell_q [NUM_PHASES];
    logic                    advance;
    logic                    tick;
    logic                    presc_clr;
    logic                    presc_en;

    // Prescaler is held clear whenever we are not in RUN, so every entry into
    // RUN starts a full tick period from zero.
    assign presc_clr = (state_q != RUN);
    assign presc_en  = (state_q == RUN);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_presc (
        .clk  (clk),
        .rst  (rst),
        .clr  (presc_clr),
        .en   (presc_en),
        .tick (tick)
    );

    // Dwell register file. Addresses without a matching phase simply never
    // match the loop index, which drops out-of-range writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_PHASES; i++) begin
                dwell_q[i] <= '0;
            end
        end else if (cfg_we) begin
            for (int i = 0; i < NUM_PHASES; i++) begin
                if (cfg_addr == PHASE_IDX_W'(i)) begin
                    dwell_q[i] <= cfg_dwell;
                end
            end
        end
    end

    always_comb begin
        cur_dwell = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            if (idx_q == PHASE_IDX_W'(i)) begin
                cur_dwell = dwell_q[i];
            end
        end
    end

    // Next phase index if an advance happens this cycle.
    always_comb begin
        adv_idx = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
`ifdef RING_REVERSE_EN
        if (dir) begin
            adv_idx = (idx_q == '0) ? LAST_IDX : idx_q - 1'b1;
        end
`endif
    end

`ifndef RING_REVERSE_EN
    logic unused_dir;
    assign unused_dir = dir;
`endif

    // Sequencer next-state logic. run has priority over step in STOP; step is
    // not looked at in RUN or STEP. Dropping run wins over a tick in the same
    // cycle, so the phase is held when stopping.
    always_comb begin
        state_d     = state_q;
        dwell_cnt_d = dwell_cnt_q;
        advance     = 1'b0;

        unique case (state_q)
            STOP: begin
                dwell_cnt_d = '0;
                if (run) begin
                    state_d = RUN;
                end else if (step) begin
                    state_d = STEP;
                end
            end

            STEP: begin
                advance = 1'b1;
                state_d = STOP;
            end

            RUN: begin
                if (!run) begin
                    state_d     = STOP;
                    dwell_cnt_d = '0;
                end else if (tick) begin
                    // >= rather than == so a dwell rewritten below the
                    // running count ends the phase on the next tick.
                    if (dwell_cnt_q >= cur_dwell) begin
                        advance     = 1'b1;
                        dwell_cnt_d = '0;
                    end else begin
                        dwell_cnt_d = dwell_cnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d     = STOP;
                dwell_cnt_d = '0;
            end
        endcase
    end

    // Output next-state: everything is derived from the next index so all
    // outputs move together on the same edge.
    always_comb begin
        idx_d     = advance ? adv_idx : idx_q;
        onehot_d  = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            onehot_d[i] = (idx_d == PHASE_IDX_W'(i));
        end
        seg_d     = seg_of(idx_d);
        strobe_d  = advance;
        running_d = (state_d == RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= STOP;
            dwell_cnt_q <= '0;
            idx_q       <= '0;
            onehot_q    <= NUM_PHASES'(1);
            seg_q       <= SEG_LUT[0];
            strobe_q    <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            dwell_cnt_q <= dwell_cnt_d;
            idx_q       <= idx_d;
            onehot_q    <= onehot_d;
            seg_q       <= seg_d;
            strobe_q    <= strobe_d;
            running_q   <= running_d;
        end
    end

    assign phase_onehot = onehot_q;
    assign phase_idx    = idx_q;
    assign seg          = seg_q;
    assign phase_strobe = strobe_q;
    assign running      = running_q;

endmodule

// File: tb/tb_ring_phase_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ring_phase_sequencer
// Self-checking bench for ring_phase_sequencer (NUM_PHASES=5, DWELL_W=8,
// TICK_DIV=4). Honours RING_REVERSE_EN when it is defined for the build.
// ---------------------------------------------------------------------------
module tb_ring_phase_sequencer;

    localparam int NP = 5;
    localparam int DW = 8;
    localparam int TD = 4;
`ifdef RING_REVERSE_EN
    localparam bit REV = 1'b1;
`else
    localparam bit REV = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          run;
    logic          step;
    logic          dir;
    logic          cfg_we;
    logic [2:0]    cfg_addr;
    logic [DW-1:0] cfg_dwell;
    logic [NP-1:0] phase_onehot;
    logic [2:0]    phase_idx;
    logic [6:0]    seg;
    logic          phase_strobe;
    logic          running;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ring_phase_sequencer #(
        .NUM_PHASES (NP),
        .DWELL_W    (DW),
        .TICK_DIV   (TD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .step         (step),
        .dir          (dir),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_dwell    (cfg_dwell),
        .phase_onehot (phase_onehot),
        .phase_idx    (phase_idx),
        .seg          (seg),
        .phase_strobe (phase_strobe),
        .running      (running)
    );

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 20)
                $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Returns number of edges until phase_strobe is seen, or -1 on timeout.
    task automatic wait_strobe(input int limit, output int n);
        n = 0;
        while (n < limit) begin
            cyc();
            n++;
            if (phase_strobe === 1'b1) return;
        end
        n = -1;
    endtask

    task automatic do_reset();
        run = 0; step = 0; dir = 0; cfg_we = 0; cfg_addr = 0; cfg_dwell = 0;
        rst = 1;
        cyc();
        rst = 0;
    endtask

    function automatic logic [6:0] lut(input int p);
        case (p)
            0:       return 7'h76;
            1:       return 7'h79;
            2:       return 7'h38;
            3:       return 7'h73;
            default: return 7'h00;
        endcase
    endfunction

    // ---------------- reference model ----------------
    // mode: 0 = stopped, 1 = running, 2 = single step pending.
    // In running mode ticks occur every TD cycles, the first TD cycles after
    // entering; m_k counts cycles since entry.
    int m_mode, m_phase, m_cnt, m_k;
    int m_dwell [8];
    bit m_strobe;

    task automatic model_reset();
        m_mode = 0; m_phase = 0; m_cnt = 0; m_k = 0; m_strobe = 0;
        for (int i = 0; i < 8; i++) m_dwell[i] = 0;
    endtask

    task automatic model_edge(input bit r, input bit s, input bit d,
                              input bit we, input int a, input int dv);
        int  nm;
        bit  tick_now;
        nm       = m_mode;
        m_strobe = 0;
        tick_now = (m_mode == 1) && (m_k > 0) && ((m_k % TD) == 0);
        case (m_mode)
            0: begin
                if (r) begin nm = 1; m_k = 0; m_cnt = 0; end
                else if (s) nm = 2;
            end
            2: begin m_strobe = 1; nm = 0; end
            default: begin
                if (!r) begin
                    nm = 0; m_cnt = 0;
                end else begin
                    if (tick_now) begin
                        if (m_cnt >= m_dwell[m_phase]) begin m_strobe = 1; m_cnt = 0; end
                        else m_cnt++;
                    end
                    m_k++;
                end
            end
        endcase
        if (m_strobe) m_phase = (REV && d) ? (m_phase + NP - 1) % NP : (m_phase + 1) % NP;
        if (we && a < NP) m_dwell[a] = dv;
        m_mode = nm;
    endtask

    function automatic logic [31:0] model_vec();
        logic [NP-1:0] oh;
        oh = NP'(1) << m_phase;
        return 32'({oh, 3'(m_phase), lut(m_phase), m_strobe, (m_mode == 1)});
    endfunction

    function automatic logic [31:0] dut_vec();
        return 32'({phase_onehot, phase_idx, seg, phase_strobe, running});
    endfunction

    // ---------------- vector table ----------------
    typedef struct packed {
        logic       run;
        logic       step;
        logic       we;
        logic [2:0] addr;
        logic [7:0] dv;
        logic [2:0] e_idx;
        logic [6:0] e_seg;
        logic       e_stb;
        logic       e_run;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    initial begin
        int n;
        int seq_seg [5];

        // run step we addr dv | idx seg stb running
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 3'd0, 7'h76, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 3'd0, 8'd0, 3'd0, 7'h76, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 3'd1, 7'h79, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 3'd1, 7'h79, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 3'd0, 8'd0, 3'd1, 7'h79, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 3'd1, 7'h79, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 3'd1, 7'h79, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 3'd1, 7'h79, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 3'd1, 7'h79, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 3'd2, 7'h38, 1'b1, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 3'd2, 7'h38, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 3'd7, 8'd9, 3'd2, 7'h38, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 3'd0, 8'd0, 3'd2, 7'h38, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 3'd3, 7'h73, 1'b1, 1'b0};

        seq_seg = '{'h79, 'h38, 'h73, 'h00, 'h76};

        // ---- reset state ----
        do_reset();
        check("rst_onehot", 32'(phase_onehot), 32'h1);
        check("rst_idx",    32'(phase_idx),    32'h0);
        check("rst_seg",    32'(seg),          32'h76);
        check("rst_strobe", 32'(phase_strobe), 32'h0);
        check("rst_running",32'(running),      32'h0);

        // ---- table: step, run-beats-step, first advance latency, stop ----
        for (int i = 0; i < NV; i++) begin
            run = vecs[i].run; step = vecs[i].step; dir = 1'b0;
            cfg_we = vecs[i].we; cfg_addr = vecs[i].addr; cfg_dwell = vecs[i].dv;
            cyc();
            check($sformatf("tbl%0d_idx", i),    32'(phase_idx),    32'(vecs[i].e_idx));
            check($sformatf("tbl%0d_onehot", i), 32'(phase_onehot), 32'(NP'(1) << vecs[i].e_idx));
            check($sformatf("tbl%0d_seg", i),    32'(seg),          32'(vecs[i].e_seg));
            check($sformatf("tbl%0d_strobe", i), 32'(phase_strobe), 32'(vecs[i].e_stb));
            check($sformatf("tbl%0d_running", i),32'(running),      32'(vecs[i].e_run));
        end
        run = 0; step = 0; cfg_we = 0;

        // ---- auto-run with all dwell 0: HELP, blank, wrap ----
        do_reset();
        run = 1;
        cyc();
        check("auto_running", 32'(running), 32'h1);
        for (int i = 0; i < 5; i++) begin
            wait_strobe(20, n);
            check($sformatf("auto_gap%0d", i), 32'(n), (i == 0) ? 32'(TD + 1) : 32'(TD));
            check($sformatf("auto_seg%0d", i), 32'(seg), 32'(seq_seg[i]));
        end
        run = 0;
        cyc();

        // ---- dwell[1]=2: phase 1 lasts 3 ticks ----
        do_reset();
        cfg_we = 1; cfg_addr = 3'd1; cfg_dwell = 8'd2;
        cyc();
        cfg_we = 0;
        run = 1;
        cyc();
        wait_strobe(40, n);
        check("dwell_enter1", 32'(n), 32'(TD + 1));
        wait_strobe(40, n);
        check("dwell_len1", 32'(n), 32'(3 * TD));
        check("dwell_idx2", 32'(phase_idx), 32'd2);
        wait_strobe(40, n);
        check("dwell_len2", 32'(n), 32'(TD));
        run = 0;
        cyc();

        // ---- single step with dir=1 ----
        do_reset();
        dir = 1; step = 1;
        cyc();
        step = 0;
        check("step_wait_strobe", 32'(phase_strobe), 32'h0);
        check("step_wait_idx",    32'(phase_idx),    32'h0);
        cyc();
        check("step1_strobe", 32'(phase_strobe), 32'h1);
        check("step1_idx", 32'(phase_idx), REV ? 32'd4 : 32'd1);
        check("step1_seg", 32'(seg),       REV ? 32'h00 : 32'h79);
        step = 1;
        cyc();
        step = 0;
        cyc();
        check("step2_idx", 32'(phase_idx), REV ? 32'd3 : 32'd2);
        check("step2_seg", 32'(seg),       REV ? 32'h73 : 32'h38);
        dir = 0;

        // ---- dwell rewrite below the running count ----
        do_reset();
        cfg_we = 1; cfg_addr = 3'd2; cfg_dwell = 8'd5;
        cyc();
        cfg_we = 0;
        run = 1;
        cyc();
        wait_strobe(40, n);
        wait_strobe(40, n);
        check("rew_in_phase2", 32'(phase_idx), 32'd2);
        repeat (13) cyc();
        cfg_we = 1; cfg_addr = 3'd2; cfg_dwell = 8'd1;
        cyc();
        cfg_we = 0;
        wait_strobe(40, n);
        check("rew_gap", 32'(n), 32'd2);
        check("rew_idx3", 32'(phase_idx), 32'd3);

        // ---- asynchronous reset mid-run at phase 3 ----
        #3 rst = 1;
        #1;
        check("arst_onehot", 32'(phase_onehot), 32'h1);
        check("arst_seg",    32'(seg),          32'h76);
        check("arst_running",32'(running),      32'h0);
        check("arst_strobe", 32'(phase_strobe), 32'h0);
        run = 0;
        cyc();
        rst = 0;

        // ---- randomized run against the model ----
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                #2 rst = 1;
                #1;
                model_reset();
                check("rand_arst", dut_vec(), model_vec());
                cyc();
                rst = 0;
            end
            if ($urandom_range(0, 19) == 0) run = ~run;
            step      = ($urandom_range(0, 7) == 0);
            dir       = 1'($urandom_range(0, 1));
            cfg_we    = ($urandom_range(0, 5) == 0);
            cfg_addr  = 3'($urandom_range(0, 7));
            cfg_dwell = DW'($urandom_range(0, 3));
            model_edge(run, step, dir, cfg_we, int'(cfg_addr), int'(cfg_dwell));
            cyc();
            check($sformatf("rand_c%0d", c), dut_vec(), model_vec());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
